// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low key matrix, debounces whole-scan results
// and encodes the single held key for the calculator control unit.
// Latency: outputs move only at a scan end, after DEBOUNCE_SCANS identical scans.
// Backpressure: none; free-running scanner, outputs are levels.
//
// Ports:
//   clock      system clock
//   reset      synchronous, active-high
//   row[3:0]   row returns, active-low, asynchronous (two-flop synchronized)
//   col[3:0]   column drive, active-low, exactly one bit low (registered)
//   button     code of the debounced key, valid while is_pressed=1
//   is_pressed high while a debounced single key is held
module keypad_scanner #(
   parameter int SCAN_DIV       = 100000,
   parameter int DEBOUNCE_SCANS = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] button,
   output logic       is_pressed
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {
      RES_NONE  = 2'd0,
      RES_KEY   = 2'd1,
      RES_MULTI = 2'd2
   } res_kind_t;

   // Legend lookup: row r, column c -> button code
   function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      case ({r, c})
         4'h0: code = 4'h1;
         4'h1: code = 4'h2;
         4'h2: code = 4'h3;
         4'h3: code = 4'hA;
         4'h4: code = 4'h4;
         4'h5: code = 4'h5;
         4'h6: code = 4'h6;
         4'h7: code = 4'hB;
         4'h8: code = 4'h7;
         4'h9: code = 4'h8;
         4'hA: code = 4'h9;
         4'hB: code = 4'hC;
         4'hC: code = 4'h0;
         4'hD: code = 4'hF;
         4'hE: code = 4'hE;
         default: code = 4'hD;
      endcase
      return code;
   endfunction

   logic [3:0]       r_row_s1;
   logic [3:0]       r_row_s2;
   logic [DIV_W-1:0] r_div;
   logic [1:0]       r_idx;
   logic [3:0]       r_col;
   res_kind_t        r_acc_kind;
   logic [3:0]       r_acc_code;
   res_kind_t        r_prev_kind;
   logic [3:0]       r_prev_code;
   logic [CNT_W-1:0] r_stable_cnt;
   logic [3:0]       r_button;
   logic             r_pressed;

   logic [2:0]       w_col_hits;
   logic [3:0]       w_col_code;
   res_kind_t        w_res_kind;
   logic [3:0]       w_res_code;
   logic             w_sample;
   logic             w_scan_end;
   logic             w_same;
   logic [CNT_W-1:0] w_cnt_next;

   assign w_sample   = (r_div == DIV_LAST);
   assign w_scan_end = w_sample && (r_idx == 2'd3);

   // Keys seen in the column currently driven
   always_comb begin
      w_col_hits = 3'd0;
      w_col_code = 4'h0;
      for (int r = 0; r < 4; r++) begin
         if (!r_row_s2[r]) begin
            w_col_hits = w_col_hits + 3'd1;
            w_col_code = key_code(2'(r), r_idx);
         end
      end
   end

   // Fold this column into the running scan result. Code is kept at 0 for
   // NONE/MULTI so that result comparison is a plain equality.
   always_comb begin
      w_res_kind = r_acc_kind;
      w_res_code = r_acc_code;
      if ((w_col_hits > 3'd1) || ((w_col_hits == 3'd1) && (r_acc_kind != RES_NONE))) begin
         w_res_kind = RES_MULTI;
         w_res_code = 4'h0;
      end else if (w_col_hits == 3'd1) begin
         w_res_kind = RES_KEY;
         w_res_code = w_col_code;
      end
   end

   assign w_same     = (w_res_kind == r_prev_kind) && (w_res_code == r_prev_code);
   assign w_cnt_next = !w_same ? CNT_W'(1) :
                       (r_stable_cnt == CNT_MAX) ? CNT_MAX : r_stable_cnt + CNT_W'(1);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_row_s1     <= 4'hF;
         r_row_s2     <= 4'hF;
         r_div        <= '0;
         r_idx        <= 2'd0;
         r_col        <= 4'b1110;
         r_acc_kind   <= RES_NONE;
         r_acc_code   <= 4'h0;
         r_prev_kind  <= RES_NONE;
         r_prev_code  <= 4'h0;
         r_stable_cnt <= '0;
         r_button     <= 4'h0;
         r_pressed    <= 1'b0;
      end else begin
         r_row_s1 <= row;
         r_row_s2 <= r_row_s1;
         if (w_sample) begin
            r_div <= '0;
            r_idx <= r_idx + 2'd1;
            r_col <= ~(4'b0001 << (r_idx + 2'd1));
            if (w_scan_end) begin
               r_acc_kind   <= RES_NONE;
               r_acc_code   <= 4'h0;
               r_prev_kind  <= w_res_kind;
               r_prev_code  <= w_res_code;
               r_stable_cnt <= w_cnt_next;
               if (w_cnt_next == CNT_MAX) begin
                  case (w_res_kind)
                     RES_NONE: r_pressed <= 1'b0;
                     RES_KEY: begin
                        if (!r_pressed) begin
                           r_button  <= w_res_code;
                           r_pressed <= 1'b1;
                        end else if (r_button != w_res_code) begin
                           // Force a low gap so the new key gets its own rising edge
                           r_pressed <= 1'b0;
                        end
                     end
                     default: ; // MULTI: ghosting/rollover never changes outputs
                  endcase
               end
            end else begin
               r_acc_kind <= w_res_kind;
               r_acc_code <= w_res_code;
            end
         end else begin
            r_div <= r_div + DIV_W'(1);
         end
      end
   end

   assign col        = r_col;
   assign button     = r_button;
   assign is_pressed = r_pressed;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2 (16-cycle scan).
// A keypad model pulls row[r] low while col[c] is low and key (r,c) is held.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_keypad_scanner;

   localparam int SCAN_DIV       = 4;
   localparam int DEBOUNCE_SCANS = 2;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] button;
   logic       is_pressed;

   logic [3:0][3:0] keys;   // keys[r][c]
   int   n_cmp   = 0;
   int   n_bad   = 0;
   int   rises   = 0;
   logic prev_pr = 1'b0;

   keypad_scanner #(
      .SCAN_DIV      (SCAN_DIV),
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .row       (row),
      .col       (col),
      .button    (button),
      .is_pressed(is_pressed)
   );

   always #5 clock = ~clock;

   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         if ((keys[r] & ~col) != 4'h0) row[r] = 1'b0;
   end

   // Advance to the next falling edge and track is_pressed rising edges
   task automatic step();
      @(negedge clock);
      if (is_pressed === 1'b1 && prev_pr !== 1'b1) rises++;
      prev_pr = is_pressed;
   endtask

   // On return the bench sits in the first cycle after reset (cycle 0)
   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic wait_pressed(input logic lvl, input int limit, output int t);
      t = -1;
      for (int i = 1; i <= limit; i++) begin
         step();
         if (is_pressed === lvl) begin
            t = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [3:0] exp_col;
      int         bad_idle;
      keys = '0;
      do_reset();
      n_cmp++; if (col !== 4'b1110) begin n_bad++; $display("FAIL reset_col: got %b expected 1110", col); end
      n_cmp++; if (button !== 4'h0) begin n_bad++; $display("FAIL reset_button: got %h expected 0", button); end
      n_cmp++; if (is_pressed !== 1'b0) begin n_bad++; $display("FAIL reset_is_pressed: got %b expected 0", is_pressed); end
      bad_idle = 0;
      for (int k = 1; k <= 20; k++) begin
         step();
         exp_col = ~(4'b0001 << ((k / 4) % 4));
         n_cmp++;
         if (col !== exp_col) begin
            n_bad++;
            $display("FAIL col_sequence cycle %0d: got %b expected %b", k, col, exp_col);
         end
         if (is_pressed !== 1'b0) bad_idle++;
      end
      n_cmp++; if (bad_idle != 0) begin n_bad++; $display("FAIL idle_no_press: is_pressed high %0d cycles, expected 0", bad_idle); end
   endtask

   task automatic test_single_key();
      int t;
      int drops;
      keys = '0;
      do_reset();
      repeat (100) step();
      keys[1][2] = 1'b1;
      wait_pressed(1'b1, 50, t);
      n_cmp++; if (t < 0) begin n_bad++; $display("FAIL key6_press_latency: is_pressed still 0 after 50 cycles, expected high within 50"); end
      n_cmp++; if (button !== 4'h6) begin n_bad++; $display("FAIL key6_button: got %h expected 6", button); end
      drops = 0;
      repeat (64) begin
         step();
         if (is_pressed !== 1'b1) drops++;
      end
      n_cmp++; if (drops != 0) begin n_bad++; $display("FAIL key6_hold: is_pressed low %0d cycles, expected 0", drops); end
      keys[1][2] = 1'b0;
      wait_pressed(1'b0, 50, t);
      n_cmp++; if (t < 0) begin n_bad++; $display("FAIL key6_release_latency: is_pressed still 1 after 50 cycles, expected low within 50"); end
      repeat (20) step();
      n_cmp++; if (button !== 4'h6) begin n_bad++; $display("FAIL key6_button_hold: got %h expected 6", button); end
      n_cmp++; if (is_pressed !== 1'b0) begin n_bad++; $display("FAIL key6_stays_released: got %b expected 0", is_pressed); end
   endtask

   task automatic test_bounce();
      int first_rise;
      int t;
      keys = '0;
      do_reset();
      repeat (32) step();
      rises = 0;
      // 12 segments of 5 cycles: down, up, down, ... ending up, then held
      for (int i = 0; i < 12; i++) begin
         keys[2][0] = (i % 2 == 0);
         repeat (5) step();
      end
      keys[2][0] = 1'b1;
      first_rise = -1;
      for (int i = 1; i <= 80; i++) begin
         step();
         if (is_pressed === 1'b1 && first_rise < 0) first_rise = i;
      end
      n_cmp++; if (rises != 1) begin n_bad++; $display("FAIL bounce_rise_count: got %0d expected 1", rises); end
      n_cmp++; if (first_rise < 32) begin n_bad++; $display("FAIL bounce_early_assert: rose after %0d held cycles, expected >= 32", first_rise); end
      n_cmp++; if (button !== 4'h7) begin n_bad++; $display("FAIL bounce_button: got %h expected 7", button); end
      keys = '0;
      wait_pressed(1'b0, 50, t);
      n_cmp++; if (t < 0) begin n_bad++; $display("FAIL bounce_release: is_pressed still 1 after 50 cycles, expected low"); end
   endtask

   task automatic test_multi_key();
      int bad;
      int t;
      keys = '0;
      do_reset();
      keys[0][0] = 1'b1;
      keys[0][1] = 1'b1;
      bad = 0;
      repeat (80) begin
         step();
         if (is_pressed !== 1'b0 || button !== 4'h0) bad++;
      end
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL multi_suppressed: outputs moved in %0d cycles, expected 0", bad); end
      keys[0][1] = 1'b0;
      wait_pressed(1'b1, 50, t);
      n_cmp++; if (t < 0) begin n_bad++; $display("FAIL multi_to_single: is_pressed still 0 after 50 cycles, expected high"); end
      n_cmp++; if (button !== 4'h1) begin n_bad++; $display("FAIL multi_to_single_button: got %h expected 1", button); end
      keys = '0;
   endtask

   task automatic test_back_to_back();
      int         t;
      int         low;
      logic [3:0] last_low_btn;
      keys = '0;
      do_reset();
      keys[1][1] = 1'b1;
      wait_pressed(1'b1, 50, t);
      n_cmp++; if (t < 0 || button !== 4'h5) begin n_bad++; $display("FAIL switch_key5: t=%0d button=%h expected press with 5", t, button); end
      repeat (5) step();
      keys[1][1] = 1'b0;
      keys[2][2] = 1'b1;
      wait_pressed(1'b0, 50, t);
      n_cmp++; if (t < 0) begin n_bad++; $display("FAIL switch_fall: is_pressed still 1 after 50 cycles, expected low"); end
      n_cmp++; if (button !== 4'h5) begin n_bad++; $display("FAIL switch_fall_button: got %h expected 5", button); end
      low = 1;
      last_low_btn = button;
      for (int i = 0; i < 60; i++) begin
         step();
         if (is_pressed === 1'b1) break;
         low++;
         last_low_btn = button;
      end
      n_cmp++; if (low != 16) begin n_bad++; $display("FAIL switch_gap: low for %0d cycles, expected 16", low); end
      n_cmp++; if (button !== 4'h9 || is_pressed !== 1'b1) begin n_bad++; $display("FAIL switch_key9: button=%h is_pressed=%b expected 9/1", button, is_pressed); end
      n_cmp++; if (last_low_btn !== 4'h5) begin n_bad++; $display("FAIL switch_button_edge: got %h before rise, expected 5", last_low_btn); end
      keys = '0;
   endtask

   task automatic test_reset_mid_scan();
      int t;
      keys = '0;
      do_reset();
      keys[3][2] = 1'b1;
      wait_pressed(1'b1, 50, t);
      n_cmp++; if (t < 0 || button !== 4'hE) begin n_bad++; $display("FAIL keyE_press: t=%0d button=%h expected press with E", t, button); end
      repeat (6) step();
      reset = 1'b1;
      step();
      n_cmp++; if (col !== 4'b1110) begin n_bad++; $display("FAIL midreset_col: got %b expected 1110", col); end
      n_cmp++; if (button !== 4'h0) begin n_bad++; $display("FAIL midreset_button: got %h expected 0", button); end
      n_cmp++; if (is_pressed !== 1'b0) begin n_bad++; $display("FAIL midreset_is_pressed: got %b expected 0", is_pressed); end
      reset = 1'b0;
      wait_pressed(1'b1, 50, t);
      // Debounce history is cleared, so two full scans (cycles 0..31) are needed
      n_cmp++; if (t < 32) begin n_bad++; $display("FAIL midreset_relatch: rose after %0d cycles, expected 32..50", t); end
      n_cmp++; if (button !== 4'hE) begin n_bad++; $display("FAIL midreset_button_E: got %h expected E", button); end
      keys = '0;
   endtask

   initial begin
      reset = 1'b1;
      keys  = '0;
      test_reset();
      test_single_key();
      test_bounce();
      test_multi_key();
      test_back_to_back();
      test_reset_mid_scan();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
